// File: rtl/if_else_select_pipe.sv
// if_else_select_pipe
// Two-stage valid/ready pipeline that evaluates a masked-compare branch
// condition and selects, per channel, between if-section and else-section
// results. S1 captures the per-channel select together with both data sets.
// S2 performs the mux and holds the registered output beat.
//
// Optional build macro: IF_ELSE_SELECT_STATS_EN
//   When defined, adds saturating 16-bit if_cnt / else_cnt output-beat counters.
module if_else_select_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int COND_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COND_W-1:0]       input_bit,
  input  logic [COND_W-1:0]       cond_mask,
  input  logic [COND_W-1:0]       cond_match,
  input  logic [NUM_CH-1:0]       ch_if_en,
  input  logic [NUM_CH*WIDTH-1:0] if_data,
  input  logic [NUM_CH*WIDTH-1:0] else_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] segment_combine,
  output logic [NUM_CH-1:0]       out_sel
`ifdef IF_ELSE_SELECT_STATS_EN
  ,
  output logic [15:0]             if_cnt,
  output logic [15:0]             else_cnt
`endif
);

  logic                    cond;
  logic [NUM_CH-1:0]       sel;
  logic                    s1_valid;
  logic [NUM_CH-1:0]       s1_sel;
  logic [NUM_CH*WIDTH-1:0] s1_if;
  logic [NUM_CH*WIDTH-1:0] s1_else;
  logic [NUM_CH*WIDTH-1:0] mux_data;
  logic                    s1_load;
  logic                    s2_load;

  // Condition and per-channel select from the live inputs; only used at handshake.
  always_comb begin
    cond = ((input_bit & cond_mask) == (cond_match & cond_mask));
    sel  = cond ? ch_if_en : '0;
  end

  // Handshake control; in_ready deliberately ignores in_valid.
  always_comb begin
    s2_load  = s1_valid & (~out_valid | out_ready);
    in_ready = ~s1_valid | s2_load;
    s1_load  = in_valid & in_ready;
  end

  // Per-channel mux out of the S1 registers.
  always_comb begin
    mux_data = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mux_data[ch*WIDTH +: WIDTH] = s1_sel[ch] ? s1_if[ch*WIDTH +: WIDTH]
                                               : s1_else[ch*WIDTH +: WIDTH];
    end
  end

  // S1: capture select and both data sets on input handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_if    <= '0;
      s1_else  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_sel   <= sel;
        s1_if    <= if_data;
        s1_else  <= else_data;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2: output register; holds stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid       <= 1'b0;
      segment_combine <= '0;
      out_sel         <= '0;
    end else begin
      if (s2_load) begin
        out_valid       <= 1'b1;
        segment_combine <= mux_data;
        out_sel         <= s1_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef IF_ELSE_SELECT_STATS_EN
  // Saturating counters of output beats by path taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_cnt   <= '0;
      else_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_sel != '0) begin
        if (if_cnt != 16'hFFFF) if_cnt <= if_cnt + 16'd1;
      end else begin
        if (else_cnt != 16'hFFFF) else_cnt <= else_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_else_select_pipe.sv
// Testbench for if_else_select_pipe: scoreboard of expected output beats
// filled at each input handshake and drained at each output handshake,
// plus per-scenario timing and stall checks.
module tb_if_else_select_pipe;
  localparam int W = 32;
  localparam int N = 4;
  localparam int C = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [C-1:0]   input_bit, cond_mask, cond_match;
  logic [N-1:0]   ch_if_en;
  logic [N*W-1:0] if_data, else_data;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] segment_combine;
  logic [N-1:0]   out_sel;
`ifdef IF_ELSE_SELECT_STATS_EN
  logic [15:0]    if_cnt, else_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int else_seen = 0;
  logic [N+N*W-1:0] sb[$];

  if_else_select_pipe #(.WIDTH(W), .NUM_CH(N), .COND_W(C)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_bit(input_bit), .cond_mask(cond_mask), .cond_match(cond_match),
    .ch_if_en(ch_if_en), .if_data(if_data), .else_data(else_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .segment_combine(segment_combine), .out_sel(out_sel)
`ifdef IF_ELSE_SELECT_STATS_EN
    , .if_cnt(if_cnt), .else_cnt(else_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: pop/compare on output handshake, push model result on input handshake.
  always @(negedge clk) begin
    logic [N+N*W-1:0] exp_beat;
    logic             c;
    logic [N-1:0]     s;
    logic [N*W-1:0]   d;
    if (reset) begin
      sb.delete();
      else_seen = 0;
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got sel=%b data=%h, expected no beat", out_sel, segment_combine);
        end else begin
          exp_beat = sb.pop_front();
          pops++;
          if (exp_beat[N+N*W-1 -: N] == '0) else_seen++;
          if ({out_sel, segment_combine} !== exp_beat) begin
            bad++;
            $display("FAIL sb_beat: got sel=%b data=%h, expected sel=%b data=%h",
                     out_sel, segment_combine, exp_beat[N+N*W-1 -: N], exp_beat[N*W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        c = ((input_bit & cond_mask) == (cond_match & cond_mask));
        s = c ? ch_if_en : '0;
        for (int ch = 0; ch < N; ch++)
          d[ch*W +: W] = s[ch] ? if_data[ch*W +: W] : else_data[ch*W +: W];
        sb.push_back({s, d});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [C-1:0] ib, input logic [C-1:0] msk,
                          input logic [C-1:0] mat, input logic [N-1:0] en,
                          input logic [N*W-1:0] idat, input logic [N*W-1:0] edat);
    input_bit  = ib;
    cond_mask  = msk;
    cond_match = mat;
    ch_if_en   = en;
    if_data    = idat;
    else_data  = edat;
    in_valid   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    input_bit = '1; cond_mask = '0; cond_match = '0; ch_if_en = '1;
    if_data = {N{32'hDEAD_BEEF}}; else_data = '0;
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || segment_combine !== '0 || out_sel !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got v=%b data=%h sel=%b rdy=%b, expected 0/0/0/1",
               out_valid, segment_combine, out_sel, in_ready);
    end
    tick();
  endtask

  // One beat, checks the 2-clock latency and the selected result.
  task automatic test_single(input string nm, input logic [C-1:0] mat,
                             input logic [N-1:0] exp_sel, input logic [N*W-1:0] exp_data);
    out_ready = 1'b1;
    set_beat(32'h0000_00A5, 32'h0000_00FF, mat, 4'b0101,
             {N{32'h1111_1111}}, {N{32'h2222_2222}});
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_rdy: got %b, expected 1", nm, in_ready);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL %s_early: out_valid got %b after 1 clock, expected 0", nm, out_valid);
    end
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_sel !== exp_sel || segment_combine !== exp_data) begin
      bad++;
      $display("FAIL %s_out: got v=%b sel=%b data=%h, expected v=1 sel=%b data=%h",
               nm, out_valid, out_sel, segment_combine, exp_sel, exp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] vhist;
    int          p0;
    p0 = pops;
    vhist = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8)
        set_beat(i[C-1:0], '0, '0, 4'b1111,
                 {32'hA000_0000 + i, 32'hB000_0000 + i, 32'hC000_0000 + i, 32'(i + 1)},
                 {N{32'hEEEE_EEEE}});
      else
        in_valid = 1'b0;
      @(negedge clk);
      vhist[i] = out_valid;
      if (i < 8) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_rdy: cycle %0d got %b, expected 1", i, in_ready);
        end
      end
      tick();
    end
    total++;
    if (vhist !== 12'b0011_1111_1100) begin
      bad++; $display("FAIL b2b_valid_pattern: got %b, expected 001111111100", vhist);
    end
    total++;
    if (pops - p0 !== 8) begin
      bad++; $display("FAIL b2b_count: got %0d beats, expected 8", pops - p0);
    end
  endtask

  task automatic test_stall();
    int               idx;
    int               p0;
    bit               held;
    logic [N*W-1:0]   held_data;
    logic [N-1:0]     held_sel;
    int               guard;
    p0 = pops; idx = 0; held = 0;
    held_data = '0; held_sel = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_beat(32'h0000_00F0 + idx, 32'h0000_000F, 32'h0000_0001, 4'b0011,
               {N{32'h5000_0000 + idx}}, {N{32'h6000_0000 + idx}});
      @(negedge clk);
      if (out_valid && !held) begin
        held = 1; held_data = segment_combine; held_sel = out_sel;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    @(negedge clk);
    total++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_hold: got accepted=%0d rdy=%b, expected 2/0", idx, in_ready);
    end
    total++;
    if (!held || out_valid !== 1'b1 || segment_combine !== held_data || out_sel !== held_sel) begin
      bad++;
      $display("FAIL stall_stable: got v=%b data=%h sel=%b, expected v=1 data=%h sel=%b",
               out_valid, segment_combine, out_sel, held_data, held_sel);
    end
    tick();
    out_ready = 1'b1;
    guard = 0;
    while ((idx < 3 || sb.size() != 0 || out_valid) && guard < 30) begin
      if (idx < 3)
        set_beat(32'h0000_00F0 + idx, 32'h0000_000F, 32'h0000_0001, 4'b0011,
                 {N{32'h5000_0000 + idx}}, {N{32'h6000_0000 + idx}});
      else
        in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    total++;
    if (guard >= 30 || pops - p0 !== 3) begin
      bad++; $display("FAIL stall_drain: got %0d beats (guard=%0d), expected 3", pops - p0, guard);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_beat(32'h1, 32'h1, 32'h1, 4'b1000, {N{32'h7700_0000 + c}}, {N{32'h8800_0000 + c}});
      tick();
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL rmid_full: got rdy=%b v=%b, expected 0/1", in_ready, out_valid);
    end
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || segment_combine !== '0 || out_sel !== '0) begin
      bad++;
      $display("FAIL rmid_flush: got v=%b data=%h sel=%b, expected 0/0/0", out_valid, segment_combine, out_sel);
    end
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL rmid_no_ghost: cycle %0d got v=%b, expected 0", c, out_valid);
      end
      tick();
    end
    test_single("rmid_post", 32'h0000_00A5, 4'b0101,
                {32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111});
  endtask

`ifdef IF_ELSE_SELECT_STATS_EN
  task automatic test_stats();
    int guard;
    out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      set_beat(32'h0, 32'h0, 32'h0, 4'b0001, {N{32'(i)}}, '0);
      tick();
    end
    in_valid = 1'b0;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 20) begin
      tick(); guard++;
    end
    @(negedge clk);
    total++;
    if (if_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL stats_if_sat: got %h, expected FFFF", if_cnt);
    end
    total++;
    if (else_cnt !== 16'(else_seen)) begin
      bad++; $display("FAIL stats_else: got %0d, expected %0d", else_cnt, else_seen);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single("cond_hit", 32'h0000_00A5, 4'b0101,
                {32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111});
    test_single("cond_miss", 32'h0000_00A4, 4'b0000, {N{32'h2222_2222}});
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef IF_ELSE_SELECT_STATS_EN
    test_stats();
`endif
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending beats, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
